// File: rtl/inference_sequencer.sv
// Central controller for the layered inference datapath.
// Walks each sample through MAC -> truncation -> activation for every layer,
// scores the final decision against the label, and maintains running
// sample/correct counts plus integer percent accuracy from a bit-serial divider.
// LAYERS must be at least 2 so that curr_layer has a non-zero width.
module inference_sequencer #(
  parameter int LAYERS     = 2,
  parameter int OUT_WIDTH  = 10,
  parameter int MAX_INPUTS = 200,
  parameter int CNT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 9,
  parameter int TIMEOUT    = 4096
) (
  input  logic                       clk,
  input  logic                       rst_overall_n,
  input  logic                       enable_inference,
  input  logic                       input_loaded,
  input  logic [LAYERS-1:0]          layer_done,
  input  logic [LAYERS-1:0]          trunc_done,
  input  logic [LAYERS-1:0]          relu_done,
  input  logic [OUT_WIDTH-1:0]       expected_output,
  input  logic [OUT_WIDTH-1:0]       obtained_output,
  output logic [LAYERS-1:0]          layer_en,
  output logic [LAYERS-1:0]          trunc_en,
  output logic [LAYERS-1:0]          relu_en,
  output logic [$clog2(LAYERS)-1:0]  curr_layer,
  output logic                       begin_next,
  output logic [CNT_WIDTH-1:0]       count,
  output logic [CNT_WIDTH-1:0]       correct,
  output logic [ACC_WIDTH-1:0]       accuracy,
  output logic                       complete,
  output logic                       timeout_err
);

  localparam int LW    = $clog2(LAYERS);
  localparam int WD_W  = $clog2(TIMEOUT);
  // Dividend is correct*100; 100 < 2^7, so seven extra bits always suffice.
  localparam int DVD_W = CNT_WIDTH + 7;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WAIT  = 4'd1;
  localparam logic [3:0] S_LRUN  = 4'd2;
  localparam logic [3:0] S_TRUN  = 4'd3;
  localparam logic [3:0] S_ARUN  = 4'd4;
  localparam logic [3:0] S_CHECK = 4'd5;
  localparam logic [3:0] S_DIV   = 4'd6;
  localparam logic [3:0] S_NEXT  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  logic [3:0]           state;
  logic [WD_W-1:0]      wd_cnt;
  logic [CNT_WIDTH-1:0] div_rem;
  logic [DVD_W-1:0]     div_quo;
  logic [CNT_WIDTH-1:0] div_dsr;
  logic [3:0]           div_cnt;

  logic [CNT_WIDTH-1:0] step_rem;
  logic [DVD_W-1:0]     step_quo;
  logic [CNT_WIDTH-1:0] nxt_count;
  logic [CNT_WIDTH-1:0] nxt_correct;
  logic                 is_match;
  logic                 wd_hit;
  logic                 last_layer;

  // One restoring-division step: shift the next dividend bit into the
  // remainder, subtract the divisor if it fits, and shift the quotient bit in.
  // The remainder stays below the divisor, so it never needs more than
  // CNT_WIDTH bits once the trial subtraction has been resolved.
  function automatic logic [CNT_WIDTH+DVD_W-1:0] div_step(
    input logic [CNT_WIDTH-1:0] rem,
    input logic [DVD_W-1:0]     quo,
    input logic [CNT_WIDTH-1:0] dsr
  );
    logic [CNT_WIDTH:0] trial;
    logic [CNT_WIDTH:0] diff;
    trial = {rem, quo[DVD_W-1]};
    diff  = trial - {1'b0, dsr};
    if (trial >= {1'b0, dsr})
      div_step = {diff[CNT_WIDTH-1:0], quo[DVD_W-2:0], 1'b1};
    else
      div_step = {trial[CNT_WIDTH-1:0], quo[DVD_W-2:0], 1'b0};
  endfunction

  function automatic logic [LAYERS-1:0] onehot(input logic [LW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scoring, divider step and watchdog decode shared by the FSM below.
  always_comb begin
    {step_rem, step_quo} = div_step(div_rem, div_quo, div_dsr);
    is_match    = (obtained_output == expected_output);
    nxt_count   = count + 1'b1;
    nxt_correct = correct + CNT_WIDTH'(is_match);
    wd_hit      = (wd_cnt == WD_W'(TIMEOUT - 1));
    last_layer  = (curr_layer == LW'(LAYERS - 1));
  end

  // Sequencer FSM: enables are single-cycle pulses cleared every cycle unless
  // a transition re-asserts one; done pulses count only for curr_layer in the
  // state that is waiting for them.
  always_ff @(posedge clk or negedge rst_overall_n) begin
    if (!rst_overall_n) begin
      state       <= S_IDLE;
      curr_layer  <= '0;
      layer_en    <= '0;
      trunc_en    <= '0;
      relu_en     <= '0;
      begin_next  <= 1'b0;
      count       <= '0;
      correct     <= '0;
      accuracy    <= '0;
      complete    <= 1'b0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      div_dsr     <= '0;
      div_cnt     <= '0;
    end else begin
      layer_en   <= '0;
      trunc_en   <= '0;
      relu_en    <= '0;
      begin_next <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable_inference && !complete) state <= S_WAIT;
        end
        S_WAIT: begin
          if (input_loaded) begin
            curr_layer <= '0;
            layer_en   <= onehot('0);
            wd_cnt     <= '0;
            state      <= S_LRUN;
          end
        end
        S_LRUN: begin
          if (layer_done[curr_layer]) begin
            trunc_en <= onehot(curr_layer);
            wd_cnt   <= '0;
            state    <= S_TRUN;
          end else if (wd_hit) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_TRUN: begin
          if (trunc_done[curr_layer]) begin
            relu_en <= onehot(curr_layer);
            wd_cnt  <= '0;
            state   <= S_ARUN;
          end else if (wd_hit) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_ARUN: begin
          if (relu_done[curr_layer]) begin
            if (last_layer) begin
              state <= S_CHECK;
            end else begin
              curr_layer <= curr_layer + 1'b1;
              layer_en   <= onehot(curr_layer + 1'b1);
              wd_cnt     <= '0;
              state      <= S_LRUN;
            end
          end else if (wd_hit) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          count   <= nxt_count;
          correct <= nxt_correct;
          div_quo <= DVD_W'(nxt_correct) * DVD_W'(100);
          div_rem <= '0;
          div_dsr <= nxt_count;
          div_cnt <= '0;
          state   <= S_DIV;
        end
        S_DIV: begin
          div_quo <= step_quo;
          div_rem <= step_rem;
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == 4'(DVD_W - 1)) begin
            accuracy   <= ACC_WIDTH'(step_quo);
            begin_next <= 1'b1;
            state      <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (count == CNT_WIDTH'(MAX_INPUTS)) begin
            complete <= 1'b1;
            state    <= S_DONE;
          end else if (enable_inference) begin
            state <= S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: an ideal done-pulse responder,
// enable tracing, latency/score checks, watchdog, run completion and
// asynchronous reset behaviour.
module tb_inference_sequencer;

  localparam int LAYERS     = 2;
  localparam int OUT_WIDTH  = 10;
  localparam int MAX_INPUTS = 200;
  localparam int CNT_WIDTH  = 8;
  localparam int ACC_WIDTH  = 9;
  localparam int TIMEOUT    = 4096;
  localparam int RESP       = 4;

  logic                 clk = 1'b0;
  logic                 rst_overall_n;
  logic                 enable_inference;
  logic                 input_loaded;
  logic [LAYERS-1:0]    layer_done, trunc_done, relu_done;
  logic [OUT_WIDTH-1:0] expected_output, obtained_output;
  logic [LAYERS-1:0]    layer_en, trunc_en, relu_en;
  logic                 curr_layer;
  logic                 begin_next;
  logic [CNT_WIDTH-1:0] count, correct;
  logic [ACC_WIDTH-1:0] accuracy;
  logic                 complete, timeout_err;

  always #5 clk = ~clk;

  inference_sequencer #(
    .LAYERS(LAYERS), .OUT_WIDTH(OUT_WIDTH), .MAX_INPUTS(MAX_INPUTS),
    .CNT_WIDTH(CNT_WIDTH), .ACC_WIDTH(ACC_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_overall_n(rst_overall_n), .enable_inference(enable_inference),
    .input_loaded(input_loaded), .layer_done(layer_done), .trunc_done(trunc_done),
    .relu_done(relu_done), .expected_output(expected_output),
    .obtained_output(obtained_output), .layer_en(layer_en), .trunc_en(trunc_en),
    .relu_en(relu_en), .curr_layer(curr_layer), .begin_next(begin_next),
    .count(count), .correct(correct), .accuracy(accuracy), .complete(complete),
    .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int n_l[LAYERS], n_t[LAYERS], n_a[LAYERS];
  int cd_l[LAYERS], cd_t[LAYERS], cd_a[LAYERS];
  int order[$];
  int lay_at[$];
  int exp_order[6] = '{0, 2, 4, 1, 3, 5};
  bit hold_trunc = 0;
  bit spur = 0;
  bit bn_seen = 0;
  int bn_cnt = 0;
  int bn_cyc = 0;
  bit rd_seen = 0;
  int rd_cyc = 0;
  int il_cyc = 0;
  int le0_cyc = 0;
  int trunc_en_cyc = 0;
  logic [CNT_WIDTH-1:0] bn_count, bn_correct;
  logic [ACC_WIDTH-1:0] bn_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_resp();
    for (int i = 0; i < LAYERS; i++) begin
      cd_l[i] = 0; cd_t[i] = 0; cd_a[i] = 0;
    end
    input_loaded = 1'b0; layer_done = '0; trunc_done = '0; relu_done = '0;
  endtask

  task automatic clear_trace();
    order.delete(); lay_at.delete();
    for (int i = 0; i < LAYERS; i++) begin
      n_l[i] = 0; n_t[i] = 0; n_a[i] = 0;
    end
    bn_cnt = 0; bn_seen = 0; rd_seen = 0;
  endtask

  // Advance one clock, observe post-edge outputs and drive the ideal
  // responder: each enable is answered by its done pulse RESP-1 cycles later.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    input_loaded = 1'b0; layer_done = '0; trunc_done = '0; relu_done = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (layer_en[i]) begin
        n_l[i]++; order.push_back(i); lay_at.push_back(int'(curr_layer));
        cd_l[i] = RESP;
        if (i == 0) le0_cyc = cyc;
      end
      if (trunc_en[i]) begin
        n_t[i]++; order.push_back(2 + i); lay_at.push_back(int'(curr_layer));
        cd_t[i] = RESP; trunc_en_cyc = cyc;
      end
      if (relu_en[i]) begin
        n_a[i]++; order.push_back(4 + i); lay_at.push_back(int'(curr_layer));
        cd_a[i] = RESP;
      end
    end
    if (begin_next) begin
      bn_cnt++; bn_seen = 1; bn_cyc = cyc;
      bn_count = count; bn_correct = correct; bn_acc = accuracy;
    end
    for (int i = 0; i < LAYERS; i++) begin
      if (cd_l[i] > 0) begin
        cd_l[i]--;
        if (cd_l[i] == 0) layer_done[i] = 1'b1;
      end
      if (cd_t[i] > 0) begin
        cd_t[i]--;
        if (cd_t[i] == 0 && !hold_trunc) begin
          trunc_done[i] = 1'b1;
          if (spur && i == 0) relu_done[0] = 1'b1;
        end
      end
      if (cd_a[i] > 0) begin
        cd_a[i]--;
        if (cd_a[i] == 0) begin
          relu_done[i] = 1'b1;
          if (i == LAYERS - 1) begin rd_seen = 1; rd_cyc = cyc; end
        end
      end
    end
    if (spur && layer_en[0]) layer_done[1] = 1'b1;
  endtask

  task automatic do_reset();
    rst_overall_n = 1'b0;
    clear_resp();
    repeat (2) tick();
    rst_overall_n = 1'b1;
    clear_resp();
    clear_trace();
  endtask

  task automatic run_sample(input logic [OUT_WIDTH-1:0] e, input logic [OUT_WIDTH-1:0] o,
                            output bit ok);
    expected_output = e; obtained_output = o; bn_seen = 0;
    tick();
    input_loaded = 1'b1; il_cyc = cyc;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (bn_seen) begin ok = 1; break; end
    end
  endtask

  task automatic check_order(input string tag);
    check({tag, "_n_enables"}, order.size(), 6);
    for (int k = 0; k < 6 && k < order.size(); k++) begin
      check({tag, "_order"}, order[k], exp_order[k]);
      check({tag, "_layer"}, lay_at[k], k / 3);
    end
  endtask

  task automatic check_score(input string tag, input int c, input int r, input int a);
    check({tag, "_count"}, bn_count, c);
    check({tag, "_correct"}, bn_correct, r);
    check({tag, "_accuracy"}, bn_acc, a);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: observed run still active expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n_ok;
    int waited;
    rst_overall_n = 1'b0; enable_inference = 1'b0;
    expected_output = '0; obtained_output = '0;
    clear_resp(); clear_trace();

    // ---- reset state
    do_reset();
    check("rst_layer_en", layer_en, 0);
    check("rst_trunc_en", trunc_en, 0);
    check("rst_relu_en", relu_en, 0);
    check("rst_curr_layer", curr_layer, 0);
    check("rst_begin_next", begin_next, 0);
    check("rst_count", count, 0);
    check("rst_correct", correct, 0);
    check("rst_accuracy", accuracy, 0);
    check("rst_complete", complete, 0);
    check("rst_timeout_err", timeout_err, 0);

    // ---- test 1: one matching sample through both layers
    enable_inference = 1'b1;
    run_sample(10'b0000000100, 10'b0000000100, ok);
    check("t1_done", ok, 1);
    check("t1_start_latency", le0_cyc - il_cyc, 1);
    check_order("t1");
    check("t1_bn_latency", bn_cyc - rd_cyc, 17);
    check_score("t1", 1, 1, 100);
    tick();
    check("t1_bn_pulse_width", bn_cnt, 1);

    // ---- test 2: match, mismatch, match
    do_reset();
    enable_inference = 1'b1;
    run_sample(10'b0000000100, 10'b0000000100, ok);
    check_score("t2_s1", 1, 1, 100);
    run_sample(10'b0000000001, 10'b0000000010, ok);
    check_score("t2_s2", 2, 1, 50);
    run_sample(10'b1000000000, 10'b1000000000, ok);
    check("t2_done", ok, 1);
    check_score("t2_s3", 3, 2, 66);
    check("t2_bn_count", bn_cnt, 3);

    // ---- test 3: spurious done pulses ignored; all-zero vectors match
    clear_trace();
    spur = 1;
    run_sample('0, '0, ok);
    spur = 0;
    check("t3_done", ok, 1);
    check_order("t3");
    check("t3_n_l1", n_l[1], 1);
    check("t3_n_a0", n_a[0], 1);
    check_score("t3", 4, 3, 75);

    // ---- test 4: watchdog on a withheld trunc_done
    clear_trace();
    hold_trunc = 1;
    expected_output = 10'd1; obtained_output = 10'd1;
    tick();
    input_loaded = 1'b1;
    waited = 0;
    while (!timeout_err && waited < TIMEOUT + 100) begin
      tick(); waited++;
    end
    check("t4_timeout_err", timeout_err, 1);
    check("t4_timeout_cycles", cyc - trunc_en_cyc, TIMEOUT);
    hold_trunc = 0;
    repeat (5) tick();
    check("t4_sticky", timeout_err, 1);
    check("t4_no_relu_en", n_a[0], 0);
    check("t4_no_begin_next", bn_cnt, 0);
    check("t4_count_kept", count, 4);
    check("t4_correct_kept", correct, 3);
    do_reset();
    check("t4_reset_clears_err", timeout_err, 0);
    check("t4_reset_count", count, 0);

    // ---- test 5: full run of MAX_INPUTS samples, 3 of every 4 correct
    enable_inference = 1'b1;
    n_ok = 0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (i % 4 != 3) run_sample(10'b0000010000, 10'b0000010000, ok);
      else            run_sample(10'b0000010000, 10'b0000100000, ok);
      if (ok) n_ok++;
      if (i == 3) check_score("t5_s4", 4, 3, 75);
      if (i == 6) check_score("t5_s7", 7, 6, 85);
      if (i == MAX_INPUTS - 2) check("t5_not_complete_early", complete, 0);
    end
    check("t5_samples_ok", n_ok, MAX_INPUTS);
    check_score("t5_final", 200, 150, 75);
    tick(); tick();
    check("t5_complete", complete, 1);
    clear_trace();
    input_loaded = 1'b1;
    repeat (20) tick();
    check("t5_no_enables", order.size(), 0);
    check("t5_complete_held", complete, 1);
    check("t5_count_held", count, 200);
    check("t5_accuracy_held", accuracy, 75);

    // ---- test 6a: asynchronous reset in the middle of the divide
    do_reset();
    enable_inference = 1'b1;
    expected_output = 10'd2; obtained_output = 10'd2;
    tick();
    input_loaded = 1'b1;
    waited = 0;
    while (!rd_seen && waited < 200) begin tick(); waited++; end
    check("t6a_reached_check", rd_seen, 1);
    repeat (5) tick();
    check("t6a_count_before", count, 1);
    #2 rst_overall_n = 1'b0;
    #1;
    check("t6a_async_count", count, 0);
    check("t6a_async_correct", correct, 0);
    check("t6a_async_bn", begin_next, 0);
    enable_inference = 1'b0;
    clear_resp(); clear_trace();
    repeat (2) tick();
    rst_overall_n = 1'b1;
    repeat (25) tick();
    check("t6a_no_begin_next", bn_cnt, 0);
    check("t6a_no_enables", order.size(), 0);
    check("t6a_count_after", count, 0);
    check("t6a_accuracy_after", accuracy, 0);

    // ---- test 6b: asynchronous reset while layer 1 MAC is running
    enable_inference = 1'b1;
    tick();
    input_loaded = 1'b1;
    waited = 0;
    while (n_l[1] == 0 && waited < 200) begin tick(); waited++; end
    check("t6b_reached_l1", layer_en[1], 1);
    check("t6b_curr_layer_before", curr_layer, 1);
    #1 rst_overall_n = 1'b0;
    #1;
    check("t6b_async_layer_en", layer_en, 0);
    check("t6b_async_curr_layer", curr_layer, 0);
    enable_inference = 1'b0;
    clear_resp(); clear_trace();
    repeat (2) tick();
    rst_overall_n = 1'b1;
    repeat (25) tick();
    check("t6b_no_begin_next", bn_cnt, 0);
    check("t6b_no_enables", order.size(), 0);
    check("t6b_count_after", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
